// File: rtl/fc_mac_engine_if.sv
// rtl/fc_mac_engine_if.sv - FC MAC engine control, activation, weight and result bundle
interface fc_mac_engine_if #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
);
  logic                              i_start;
  logic                              i_relu;
  logic [8:0][DATA_W-1:0]            i_act;
  logic [1:0]                        o_addr;
  logic [9:0][2:0][DATA_W-1:0]       i_weight;
  logic                              o_busy;
  logic                              o_valid;
  logic [9:0][ACC_W-1:0]             o_result;
  logic [3:0]                        o_class;

  modport slave (
    input  i_start, i_relu, i_act, i_weight,
    output o_addr, o_busy, o_valid, o_result, o_class
  );

  modport master (
    output i_start, i_relu, i_act, i_weight,
    input  o_addr, o_busy, o_valid, o_result, o_class
  );
endinterface

// File: rtl/fc_mac_engine.sv
// rtl/fc_mac_engine.sv - 9-input, 10-neuron MAC sequencer with optional ReLU and argmax
module fc_mac_engine #(
  parameter int DATA_W = 8,
  parameter int ACC_W  = 20
) (
  input  logic               i_clk,
  input  logic               i_rst,
  fc_mac_engine_if.slave     bus
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              step_q, step_d;
  logic [8:0][DATA_W-1:0]  act_q, act_d;
  logic                    relu_q, relu_d;
  logic [9:0][ACC_W-1:0]   acc_q, acc_d;
  logic [9:0][ACC_W-1:0]   result_q, result_d;
  logic [3:0]              class_q, class_d;

  logic [9:0][ACC_W-1:0]   sum_c;
  logic [9:0][ACC_W-1:0]   final_c;
  logic [3:0]              best_c;

  // One 3-element slice per step; the buffer answers o_addr in the same cycle.
  always_comb begin : mac
    logic signed [2*DATA_W-1:0] prod;
    logic [3:0]                 idx;
    sum_c = acc_q;
    for (int n = 0; n < 10; n++) begin
      for (int j = 0; j < 3; j++) begin
        idx  = {2'b00, step_q} * 4'd3 + 4'(j);
        prod = $signed(act_q[idx]) * $signed(bus.i_weight[n][j]);
        sum_c[n] = sum_c[n] + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
      end
    end
  end

  // Strict greater-than keeps the lowest index among equal maxima.
  always_comb begin : rectify_argmax
    best_c = 4'd0;
    for (int n = 0; n < 10; n++) begin
      final_c[n] = (relu_q && sum_c[n][ACC_W-1]) ? '0 : sum_c[n];
    end
    for (int n = 1; n < 10; n++) begin
      if ($signed(final_c[n]) > $signed(final_c[best_c])) begin
        best_c = 4'(n);
      end
    end
  end

  always_comb begin : next_state
    state_d  = state_q;
    step_d   = step_q;
    act_d    = act_q;
    relu_d   = relu_q;
    acc_d    = acc_q;
    result_d = result_q;
    class_d  = class_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (bus.i_start) begin
          state_d = RUN;
          act_d   = bus.i_act;
          relu_d  = bus.i_relu;
          acc_d   = '0;
          step_d  = 2'd0;
        end
      end
      RUN: begin
        acc_d = sum_c;
        if (step_q == 2'd2) begin
          state_d  = DONE;
          step_d   = 2'd0;
          result_d = final_c;
          class_d  = best_c;
        end else begin
          step_d = step_q + 2'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q  <= IDLE;
      step_q   <= 2'd0;
      act_q    <= '0;
      relu_q   <= 1'b0;
      acc_q    <= '0;
      result_q <= '0;
      class_q  <= 4'd0;
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      act_q    <= act_d;
      relu_q   <= relu_d;
      acc_q    <= acc_d;
      result_q <= result_d;
      class_q  <= class_d;
    end
  end

  assign bus.o_addr   = step_q;
  assign bus.o_busy   = (state_q == RUN);
  assign bus.o_valid  = (state_q == DONE);
  assign bus.o_result = result_q;
  assign bus.o_class  = class_q;
endmodule

// File: tb/tb_fc_mac_engine.sv
// tb/tb_fc_mac_engine.sv - directed bench with a dot-product timeline model for fc_mac_engine
module tb_fc_mac_engine;
  localparam int DATA_W = 8;
  localparam int ACC_W  = 20;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  fc_mac_engine_if #(.DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  fc_mac_engine #(.DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int w_tab [10][9];

  // Weight buffer stand-in: returns the slice for the address currently presented.
  always_comb begin
    for (int n = 0; n < 10; n++)
      for (int j = 0; j < 3; j++)
        bus.i_weight[n][j] = 8'(w_tab[n][int'(bus.o_addr) * 3 + j]);
  end

  // Model: a phase counter since the accepted start and full 9-term dot products.
  int ph;
  int m_act [9];
  bit m_relu;
  int exp_res [10];
  int exp_cls;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ph = 0;
      exp_cls = 0;
      for (int n = 0; n < 10; n++) exp_res[n] = 0;
    end else if (ph == 1 || ph == 2) begin
      ph = ph + 1;
    end else if (ph == 3) begin
      for (int n = 0; n < 10; n++) begin
        int s;
        s = 0;
        for (int k = 0; k < 9; k++) s += m_act[k] * w_tab[n][k];
        if (m_relu && s < 0) s = 0;
        exp_res[n] = s;
      end
      exp_cls = 0;
      for (int n = 1; n < 10; n++) if (exp_res[n] > exp_res[exp_cls]) exp_cls = n;
      ph = 4;
    end else if (bus.i_start) begin
      for (int k = 0; k < 9; k++) m_act[k] = int'($signed(bus.i_act[k]));
      m_relu = bus.i_relu;
      ph = 1;
    end else begin
      ph = 0;
    end
  end

  task automatic check(input string name, input int got, input int want);
    n_tests++;
    if (got != want) begin
      n_fail++;
      $display("FAIL %s: got %0d required %0d at %0t", name, got, want, $time);
    end
  endtask

  always @(negedge clk) begin
    check("busy",  int'(bus.o_busy),  (ph >= 1 && ph <= 3) ? 1 : 0);
    check("addr",  int'(bus.o_addr),  (ph >= 1 && ph <= 3) ? ph - 1 : 0);
    check("valid", int'(bus.o_valid), (ph == 4) ? 1 : 0);
    check("class", int'(bus.o_class), exp_cls);
    for (int n = 0; n < 10; n++)
      check($sformatf("result[%0d]", n), int'($signed(bus.o_result[n])), exp_res[n]);
  end

  task automatic set_act(input int a [9], input bit relu);
    for (int k = 0; k < 9; k++) bus.i_act[k] = 8'(a[k]);
    bus.i_relu = relu;
  endtask

  task automatic start_vec(input int a [9], input bit relu);
    @(posedge clk);
    #2;
    set_act(a, relu);
    bus.i_start = 1'b1;
    @(posedge clk);
    #2;
    bus.i_start = 1'b0;
  endtask

  task automatic wait_valid(output int lat, output int addr_seq [4]);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (lat <= 3) addr_seq[lat] = int'(bus.o_addr);
    end while (!bus.o_valid && lat < 12);
  endtask

  function automatic int res(input int n);
    return int'($signed(bus.o_result[n]));
  endfunction

  int a [9];
  int lat;
  int aseq [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst = 1'b1;
    bus.i_start = 1'b0;
    bus.i_relu  = 1'b0;
    bus.i_act   = '0;
    for (int n = 0; n < 10; n++) for (int k = 0; k < 9; k++) w_tab[n][k] = 0;
    repeat (2) @(posedge clk);
    #2;
    rst = 1'b0;
    @(negedge clk);
    check("reset busy", int'(bus.o_busy), 0);
    check("reset result0", res(0), 0);

    // All ones: sums of 9, tie resolves to class 0, address walk 0,1,2.
    for (int k = 0; k < 9; k++) a[k] = 1;
    for (int n = 0; n < 10; n++) for (int k = 0; k < 9; k++) w_tab[n][k] = 1;
    start_vec(a, 1'b0);
    wait_valid(lat, aseq);
    check("lat ones", lat, 4);
    check("addr step0", aseq[1], 0);
    check("addr step1", aseq[2], 1);
    check("addr step2", aseq[3], 2);
    check("ones r0", res(0), 9);
    check("ones r9", res(9), 9);
    check("ones class", int'(bus.o_class), 0);

    // Signed extremes.
    for (int k = 0; k < 9; k++) a[k] = -128;
    for (int n = 0; n < 10; n++) for (int k = 0; k < 9; k++) w_tab[n][k] = -128;
    start_vec(a, 1'b0);
    wait_valid(lat, aseq);
    check("neg*neg r4", res(4), 147456);
    for (int n = 0; n < 10; n++) for (int k = 0; k < 9; k++) w_tab[n][k] = 127;
    start_vec(a, 1'b0);
    wait_valid(lat, aseq);
    check("neg*pos r7", res(7), -146304);
    check("neg*pos class", int'(bus.o_class), 0);

    // Ramp activations, neuron weights n-5, with and without ReLU.
    for (int k = 0; k < 9; k++) a[k] = k;
    for (int n = 0; n < 10; n++) for (int k = 0; k < 9; k++) w_tab[n][k] = n - 5;
    start_vec(a, 1'b0);
    wait_valid(lat, aseq);
    check("ramp r0", res(0), -180);
    check("ramp r9", res(9), 144);
    check("ramp class", int'(bus.o_class), 9);
    start_vec(a, 1'b1);
    wait_valid(lat, aseq);
    check("relu r0", res(0), 0);
    check("relu r6", res(6), 36);
    check("relu class", int'(bus.o_class), 9);

    // Starts during RUN ignored; act/relu changes after the start cycle ignored.
    for (int k = 0; k < 9; k++) a[k] = 9 - k;
    start_vec(a, 1'b0);
    bus.i_start = 1'b1;
    for (int k = 0; k < 9; k++) bus.i_act[k] = 8'(-3);
    bus.i_relu = 1'b1;
    @(posedge clk);
    #2;
    @(posedge clk);
    #2;
    bus.i_start = 1'b0;
    wait_valid(lat, aseq);
    check("ignore lat", lat, 2);
    check("latched r0", res(0), -225);

    // Start in the DONE cycle with a new vector and new weights.
    #1;
    for (int k = 0; k < 9; k++) a[k] = 2;
    for (int n = 0; n < 10; n++) for (int k = 0; k < 9; k++) w_tab[n][k] = (n == 3) ? 7 : 1;
    set_act(a, 1'b0);
    bus.i_start = 1'b1;
    @(posedge clk);
    #2;
    bus.i_start = 1'b0;
    wait_valid(lat, aseq);
    check("done-start lat", lat, 4);
    check("done-start r3", res(3), 126);
    check("done-start class", int'(bus.o_class), 3);

    // Asynchronous reset in the middle of a run.
    for (int k = 0; k < 9; k++) a[k] = 5;
    start_vec(a, 1'b0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("arst busy", int'(bus.o_busy), 0);
    check("arst addr", int'(bus.o_addr), 0);
    check("arst valid", int'(bus.o_valid), 0);
    check("arst r3", res(3), 0);
    check("arst class", int'(bus.o_class), 0);
    @(posedge clk);
    #2;
    rst = 1'b0;
    repeat (4) @(posedge clk);
    start_vec(a, 1'b0);
    wait_valid(lat, aseq);
    check("post-rst lat", lat, 4);
    check("post-rst r3", res(3), 315);
    check("post-rst r0", res(0), 45);
    repeat (3) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
